// File: rtl/udp_cmd_pkg.sv
// Shared constants for the UDP command controller: opcode defaults,
// broadcast channel index and FSM state encoding.
package udp_cmd_pkg;

    localparam logic [7:0] OP_START_DEF = 8'h31;
    localparam logic [7:0] OP_STOP_DEF  = 8'h30;
    localparam logic [7:0] OP_KEEP_DEF  = 8'h4B;
    localparam logic [7:0] OP_MODE_DEF  = 8'h4D;

    localparam logic [7:0] CH_BCAST = 8'hFF;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CAPT = 2'd1,
        EXEC = 2'd2
    } state_e;

endpackage

// File: rtl/udp_cmd_wdog.sv
// Keepalive watchdog: counts cycles while any channel is active and flags
// expiry on the last cycle of the window. TIMEOUT_CYC = 0 disables it.
module udp_cmd_wdog #(
    parameter int TIMEOUT_CYC = 125000000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic kick,
    input  logic active,
    output logic expire
);

    localparam int CNT_W = (TIMEOUT_CYC > 0) ? $clog2(TIMEOUT_CYC + 1) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = (TIMEOUT_CYC > 0) ? CNT_W'(TIMEOUT_CYC - 1) : '0;

    logic [CNT_W-1:0] cnt_q, cnt_d;

    // count only while active and not kicked; anything else reloads to zero
    always_comb begin
        cnt_d = '0;
        if (TIMEOUT_CYC > 0 && active && !kick) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    assign expire = (TIMEOUT_CYC > 0) && active && (cnt_q == CNT_LAST);

    // counter register with synchronous reset
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/udp_cmd_ctrl.sv
// UDP command decoder: captures the first word of each packet, decodes it
// at end of packet and updates per-channel transfer flags and modes.
//
//   state | meaning
//   IDLE  | waiting for the first word of a packet
//   CAPT  | first word held, ignoring further words until pkt_done
//   EXEC  | decode captured command, apply it and pulse ack/err
module udp_cmd_ctrl
    import udp_cmd_pkg::*;
#(
    parameter int         CH_NUM      = 4,
    parameter int         TIMEOUT_CYC = 125000000,
    parameter logic [7:0] OP_START    = OP_START_DEF,
    parameter logic [7:0] OP_STOP     = OP_STOP_DEF,
    parameter logic [7:0] OP_KEEP     = OP_KEEP_DEF,
    parameter logic [7:0] OP_MODE     = OP_MODE_DEF
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  udp_rec_pkt_done,
    input  logic                  udp_rec_en,
    input  logic [31:0]           udp_rec_data,
    input  logic [15:0]           udp_rec_byte_num,
    output logic [CH_NUM-1:0]     transfer_flag,
    output logic [2*CH_NUM-1:0]   ch_mode,
    output logic                  cmd_ack,
    output logic                  cmd_err,
    output logic                  timeout_evt
);

    state_e                state_q, state_d;
    logic [7:0]            op_q, op_d;
    logic [7:0]            ch_q, ch_d;
    logic [1:0]            arg_q, arg_d;
    logic                  len_one_q, len_one_d;
    logic                  len_ext_q, len_ext_d;
    logic [CH_NUM-1:0]     flags_q, flags_d;
    logic [2*CH_NUM-1:0]   mode_q, mode_d;
    logic                  ack_q, ack_d;
    logic                  err_q, err_d;
    logic                  tmo_q, tmo_d;
    logic                  kick;
    logic                  expire;
    logic [CH_NUM-1:0]     ch_mask;
    logic                  ch_ok;
    logic                  unused_data;

    // byte3 and the upper bits of byte2 carry no meaning
    assign unused_data = ^{udp_rec_data[15:10], udp_rec_data[7:0]};

    // channel byte of the captured command -> channel select mask
    always_comb begin
        ch_mask = '0;
        ch_ok   = 1'b0;
        if (ch_q == CH_BCAST) begin
            ch_mask = '1;
            ch_ok   = 1'b1;
        end else begin
            for (int i = 0; i < CH_NUM; i++) begin
                if (ch_q == 8'(i)) begin
                    ch_mask[i] = 1'b1;
                    ch_ok      = 1'b1;
                end
            end
        end
    end

    // next-state, capture, decode and watchdog-expiry logic
    always_comb begin
        state_d   = state_q;
        op_d      = op_q;
        ch_d      = ch_q;
        arg_d     = arg_q;
        len_one_d = len_one_q;
        len_ext_d = len_ext_q;
        flags_d   = flags_q;
        mode_d    = mode_q;
        ack_d     = 1'b0;
        err_d     = 1'b0;
        tmo_d     = 1'b0;
        kick      = 1'b0;
        case (state_q)
            IDLE: begin
                if (udp_rec_en) begin
                    op_d  = udp_rec_data[31:24];
                    ch_d  = udp_rec_data[23:16];
                    arg_d = udp_rec_data[9:8];
                    if (udp_rec_pkt_done) begin
                        len_one_d = (udp_rec_byte_num == 16'd1);
                        len_ext_d = (udp_rec_byte_num >= 16'd4);
                        state_d   = EXEC;
                    end else begin
                        state_d = CAPT;
                    end
                end else if (udp_rec_pkt_done) begin
                    // end of packet without any word: nothing to decode
                    err_d = 1'b1;
                end
            end
            CAPT: begin
                if (udp_rec_pkt_done) begin
                    len_one_d = (udp_rec_byte_num == 16'd1);
                    len_ext_d = (udp_rec_byte_num >= 16'd4);
                    state_d   = EXEC;
                end
            end
            EXEC: begin
                state_d = IDLE;
                if (len_one_q) begin
                    if (op_q == OP_START) begin
                        flags_d = '1;
                        kick    = 1'b1;
                    end else if (op_q == OP_STOP) begin
                        flags_d = '0;
                        kick    = 1'b1;
                    end
                end else if (len_ext_q && ch_ok) begin
                    if (op_q == OP_START) begin
                        flags_d = flags_q | ch_mask;
                        kick    = 1'b1;
                    end else if (op_q == OP_STOP) begin
                        flags_d = flags_q & ~ch_mask;
                        kick    = 1'b1;
                    end else if (op_q == OP_MODE) begin
                        for (int i = 0; i < CH_NUM; i++) begin
                            if (ch_mask[i]) begin
                                mode_d[2*i +: 2] = arg_q;
                            end
                        end
                        kick = 1'b1;
                    end else if (op_q == OP_KEEP) begin
                        kick = 1'b1;
                    end
                end
                ack_d = kick;
                err_d = ~kick;
            end
            default: state_d = IDLE;
        endcase
        // an accepted command in the same cycle wins over the timeout
        if (expire && !kick) begin
            flags_d = '0;
            tmo_d   = 1'b1;
        end
    end

    // all state and registered outputs, synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            op_q      <= '0;
            ch_q      <= '0;
            arg_q     <= '0;
            len_one_q <= 1'b0;
            len_ext_q <= 1'b0;
            flags_q   <= '0;
            mode_q    <= '0;
            ack_q     <= 1'b0;
            err_q     <= 1'b0;
            tmo_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            op_q      <= op_d;
            ch_q      <= ch_d;
            arg_q     <= arg_d;
            len_one_q <= len_one_d;
            len_ext_q <= len_ext_d;
            flags_q   <= flags_d;
            mode_q    <= mode_d;
            ack_q     <= ack_d;
            err_q     <= err_d;
            tmo_q     <= tmo_d;
        end
    end

    udp_cmd_wdog #(
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) u_wdog (
        .clk    (clk),
        .rst_n  (rst_n),
        .kick   (kick),
        .active (|flags_q),
        .expire (expire)
    );

    assign transfer_flag = flags_q;
    assign ch_mode       = mode_q;
    assign cmd_ack       = ack_q;
    assign cmd_err       = err_q;
    assign timeout_evt   = tmo_q;

endmodule

// File: tb/tb_udp_cmd_ctrl.sv
// Bench for udp_cmd_ctrl with CH_NUM = 4, TIMEOUT_CYC = 100: directed cases
// followed by random packets against a packet-level reference model.
module tb_udp_cmd_ctrl;

    localparam int TMO = 100;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        pkt_done = 1'b0;
    logic        rec_en = 1'b0;
    logic [31:0] rec_data = '0;
    logic [15:0] byte_num = '0;
    logic [3:0]  transfer_flag;
    logic [7:0]  ch_mode;
    logic        cmd_ack, cmd_err, timeout_evt;

    int n_chk = 0, n_pass = 0;
    int cyc = 0, tmo_seen = 0, tmo_exp = 0, last_kick = 0;
    bit m_flag[4];
    int m_mode[4];

    udp_cmd_ctrl #(
        .CH_NUM      (4),
        .TIMEOUT_CYC (TMO)
    ) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .udp_rec_pkt_done (pkt_done),
        .udp_rec_en       (rec_en),
        .udp_rec_data     (rec_data),
        .udp_rec_byte_num (byte_num),
        .transfer_flag    (transfer_flag),
        .ch_mode          (ch_mode),
        .cmd_ack          (cmd_ack),
        .cmd_err          (cmd_err),
        .timeout_evt      (timeout_evt)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    always @(negedge clk) if (timeout_evt === 1'b1) tmo_seen++;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
        else n_pass++;
    endtask

    function automatic logic [3:0] pack_flags();
        logic [3:0] r;
        for (int i = 0; i < 4; i++) r[i] = m_flag[i];
        return r;
    endfunction

    function automatic logic [7:0] pack_mode();
        logic [7:0] r;
        for (int i = 0; i < 4; i++) r[2*i +: 2] = 2'(m_mode[i]);
        return r;
    endfunction

    // a running channel times out TMO edges after the last accepted command
    function automatic void catchup(input int now);
        bit any;
        any = 0;
        for (int i = 0; i < 4; i++) any |= m_flag[i];
        if (any && last_kick + TMO <= now) begin
            for (int i = 0; i < 4; i++) m_flag[i] = 0;
            tmo_exp++;
        end
    endfunction

    function automatic void model_reset();
        for (int i = 0; i < 4; i++) begin
            m_flag[i] = 0;
            m_mode[i] = 0;
        end
        last_kick = cyc;
    endfunction

    task automatic model_step(input logic [7:0] op, input logic [7:0] ch, input logic [1:0] arg,
                              input int bn, input int a, output bit acc);
        bit ch_valid;
        ch_valid = (ch == 8'hFF) || (ch < 8'd4);
        if (bn == 1) acc = (op == 8'h31) || (op == 8'h30);
        else if (bn >= 4) acc = ch_valid && (op == 8'h31 || op == 8'h30 || op == 8'h4B || op == 8'h4D);
        else acc = 0;
        if (acc) catchup(a - 1);
        else catchup(a);
        if (acc) begin
            last_kick = a;
            for (int c = 0; c < 4; c++) begin
                if (bn == 1) m_flag[c] = (op == 8'h31);
                else if (ch == 8'hFF || ch == 8'(c)) begin
                    if (op == 8'h31) m_flag[c] = 1;
                    else if (op == 8'h30) m_flag[c] = 0;
                    else if (op == 8'h4D) m_mode[c] = int'(arg);
                end
            end
        end
    endtask

    // send one packet (called at #1 after an edge), then check its outcome
    task automatic send_pkt(input logic [7:0] op, input logic [7:0] ch, input logic [1:0] arg,
                            input int bn, input int nwords, input bit same_cyc);
        logic [31:0] w0;
        bit acc;
        w0 = {op, ch, 6'($urandom), arg, 8'($urandom)};
        if (same_cyc) begin
            rec_en = 1; rec_data = w0; pkt_done = 1; byte_num = 16'(bn);
            @(posedge clk); #1;
        end else begin
            for (int w = 0; w < nwords; w++) begin
                rec_en = 1;
                rec_data = (w == 0) ? w0 : $urandom;
                @(posedge clk); #1;
            end
            rec_en = 0; pkt_done = 1; byte_num = 16'(bn);
            @(posedge clk); #1;
        end
        rec_en = 0; pkt_done = 0; rec_data = $urandom; byte_num = 16'($urandom);
        check_val("ack_early", cmd_ack, 0);
        check_val("err_early", cmd_err, 0);
        @(posedge clk); #1;
        model_step(op, ch, arg, bn, cyc, acc);
        check_val("flags", transfer_flag, pack_flags());
        check_val("mode", ch_mode, pack_mode());
        check_val("ack", cmd_ack, acc);
        check_val("err", cmd_err, !acc);
        @(posedge clk); #1;
        check_val("ack_width", cmd_ack, 0);
        check_val("err_width", cmd_err, 0);
        check_val("tmo_count", tmo_seen, tmo_exp);
    endtask

    initial begin
        logic [7:0] op_tbl [5];
        logic [7:0] op, ch;
        int bn, nw;
        bit sc;

        // reset state
        repeat (3) @(posedge clk);
        #1;
        model_reset();
        check_val("rst_flags", transfer_flag, 0);
        check_val("rst_mode", ch_mode, 0);
        check_val("rst_pulses", {cmd_ack, cmd_err, timeout_evt}, 0);
        rst_n = 1;
        @(posedge clk); #1;

        // legacy start
        send_pkt(8'h31, 8'h00, 2'd0, 1, 1, 0);
        check_val("legacy_start", transfer_flag, 4'b1111);
        send_pkt(8'h30, 8'h00, 2'd0, 1, 1, 0);
        check_val("legacy_stop", transfer_flag, 4'b0000);
        send_pkt(8'h5A, 8'h00, 2'd0, 1, 1, 0);

        // extended start on channel 2, then broadcast mode 3
        send_pkt(8'h31, 8'h02, 2'd0, 4, 1, 0);
        send_pkt(8'h4D, 8'hFF, 2'd3, 4, 1, 0);
        check_val("ext_flags", transfer_flag, 4'b0100);
        check_val("ext_mode", ch_mode, 8'hFF);

        // rejections
        send_pkt(8'h31, 8'h05, 2'd0, 4, 1, 0);
        send_pkt(8'h31, 8'h01, 2'd0, 2, 1, 0);
        send_pkt(8'h30, 8'hFF, 2'd0, 0, 1, 0);
        send_pkt(8'h31, 8'h01, 2'd0, 3, 1, 0);
        check_val("rej_flags", transfer_flag, 4'b0100);

        // pkt_done with no word
        pkt_done = 1; byte_num = 16'd4;
        @(posedge clk); #1;
        pkt_done = 0;
        check_val("orphan_err", cmd_err, 1);
        check_val("orphan_ack", cmd_ack, 0);
        @(posedge clk); #1;
        catchup(cyc);
        check_val("orphan_err_width", cmd_err, 0);
        check_val("orphan_flags", transfer_flag, pack_flags());

        // same-cycle word and pkt_done; multi-word packet
        send_pkt(8'h31, 8'h00, 2'd0, 4, 1, 1);
        send_pkt(8'h4D, 8'h01, 2'd2, 8, 3, 0);
        check_val("multi_mode", ch_mode, 8'hFB);

        // watchdog: start, then silence for the full window
        send_pkt(8'h31, 8'hFF, 2'd0, 4, 1, 0);
        repeat (98) @(posedge clk);
        #1;
        check_val("wd_before_flags", transfer_flag, 4'b1111);
        check_val("wd_before_evt", timeout_evt, 0);
        @(posedge clk); #1;
        check_val("wd_flags", transfer_flag, 4'b0000);
        check_val("wd_evt", timeout_evt, 1);
        check_val("wd_mode_kept", ch_mode, 8'hFB);
        @(posedge clk); #1;
        check_val("wd_evt_width", timeout_evt, 0);
        catchup(cyc - 1);

        // keepalive every 50 cycles holds the channels on
        send_pkt(8'h31, 8'hFF, 2'd0, 4, 1, 0);
        for (int k = 0; k < 6; k++) begin
            repeat (46) @(posedge clk);
            #1;
            send_pkt(8'h4B, 8'hFF, 2'd0, 4, 1, 0);
        end
        check_val("keep_flags", transfer_flag, 4'b1111);

        // reset in the middle of a packet
        rec_en = 1; rec_data = 32'h31FF0000;
        @(posedge clk); #1;
        rec_en = 0;
        catchup(cyc);
        rst_n = 0;
        repeat (2) @(posedge clk);
        #1;
        model_reset();
        rst_n = 1;
        repeat (3) @(posedge clk);
        #1;
        check_val("midrst_flags", transfer_flag, 0);
        check_val("midrst_mode", ch_mode, 0);
        check_val("midrst_pulses", {cmd_ack, cmd_err, timeout_evt}, 0);
        send_pkt(8'h31, 8'h03, 2'd0, 4, 1, 0);
        check_val("post_rst_cmd", transfer_flag, 4'b1000);

        // random packets
        op_tbl[0] = 8'h31; op_tbl[1] = 8'h30; op_tbl[2] = 8'h4B; op_tbl[3] = 8'h4D; op_tbl[4] = 8'h00;
        for (int n = 0; n < 40; n++) begin
            op = op_tbl[$urandom_range(0, 4)];
            if (op == 8'h00) op = 8'($urandom);
            case ($urandom_range(0, 5))
                4: ch = 8'hFF;
                5: ch = 8'($urandom);
                default: ch = 8'($urandom_range(0, 3));
            endcase
            case ($urandom_range(0, 7))
                0: bn = 0;
                1, 2: bn = 1;
                3: bn = $urandom_range(2, 3);
                default: bn = $urandom_range(4, 1500);
            endcase
            nw = $urandom_range(1, 3);
            sc = ($urandom_range(0, 4) == 0);
            send_pkt(op, ch, 2'($urandom), bn, nw, sc);
            repeat ($urandom_range(0, 80)) @(posedge clk);
            #1;
        end

        // drain: any channel still on must time out
        repeat (TMO + 20) @(posedge clk);
        @(negedge clk); #1;
        catchup(cyc);
        check_val("final_flags", transfer_flag, pack_flags());
        check_val("final_tmo_count", tmo_seen, tmo_exp);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/udp_cmd_ctrl.md
UDP_CMD_CTRL -- requirements
Module: udp_cmd_ctrl

Interface
REQ-001 SHALL have parameter CH_NUM, default 4: number of transfer channels, legal range 1..8.
REQ-002 SHALL have parameter TIMEOUT_CYC, default 125000000: keepalive watchdog length in clk cycles; 0 disables the watchdog.
REQ-003 SHALL have parameters OP_START 8'h31 ("1"), OP_STOP 8'h30 ("0"), OP_KEEP 8'h4B ("K") and OP_MODE 8'h4D ("M"): command opcodes.
REQ-004 SHALL have port clk, input, 1 bit: single clock; all logic is on the rising edge.
REQ-005 SHALL have port rst_n, input, 1 bit: reset, synchronous and active-low.
REQ-006 SHALL have port udp_rec_pkt_done, input, 1 bit: one-cycle pulse marking the end of a received UDP packet.
REQ-007 SHALL have port udp_rec_en, input, 1 bit: qualifies udp_rec_data for one 32-bit word.
REQ-008 SHALL have port udp_rec_data, input, 32 bits: received word, first byte in [31:24].
REQ-009 SHALL have port udp_rec_byte_num, input, 16 bits: packet payload length in bytes, valid with udp_rec_pkt_done.
REQ-010 SHALL have port transfer_flag, output, CH_NUM bits: per-channel transfer enable, 1 = transfer.
REQ-011 SHALL have port ch_mode, output, 2*CH_NUM bits: per-channel 2-bit mode, channel i in [2i+1:2i].
REQ-012 SHALL have port cmd_ack, output, 1 bit: one-cycle pulse when a command is accepted.
REQ-013 SHALL have port cmd_err, output, 1 bit: one-cycle pulse when a command is rejected.
REQ-014 SHALL have port timeout_evt, output, 1 bit: one-cycle pulse when the watchdog stops all channels.

Function
REQ-015 SHALL capture only the first udp_rec_en word of each packet; later words in the same packet are ignored.
REQ-016 SHALL use an FSM with states IDLE, CAPT and EXEC:
- IDLE -> CAPT on udp_rec_en.
- CAPT -> EXEC on udp_rec_pkt_done.
- EXEC -> IDLE unconditionally after 1 cycle.
REQ-017 SHALL, when udp_rec_en and udp_rec_pkt_done are high in the same cycle in IDLE, capture that word and go directly to EXEC.
REQ-018 SHALL, on udp_rec_pkt_done in IDLE with no captured word, pulse cmd_err once, leave all outputs unchanged and stay in IDLE.
REQ-019 SHALL treat a packet of byte_num == 1 as a legacy command: OP_START sets all transfer_flag bits, OP_STOP clears all of them, any other opcode is rejected.
REQ-020 SHALL treat a packet of byte_num >= 4 as an extended command: byte0 = opcode, byte1 = channel (0..CH_NUM-1, or 8'hFF = all channels), byte2[1:0] = mode argument, byte3 ignored.
REQ-021 SHALL execute extended commands as follows:
- OP_START sets the flag(s) of the addressed channel(s).
- OP_STOP clears the flag(s).
- OP_MODE writes ch_mode of the addressed channel(s) and leaves flags unchanged.
- OP_KEEP changes no state and only restarts the watchdog.
REQ-022 SHALL reject any packet with byte_num of 0, 2 or 3, an unknown opcode, or a channel index >= CH_NUM other than 8'hFF; a rejected packet pulses cmd_err and changes no state.
REQ-023 SHALL apply state updates and the cmd_ack/cmd_err pulse in the EXEC cycle, so that outputs change on the edge 2 cycles after the pkt_done edge.
REQ-024 SHALL reload the watchdog counter to 0 on every accepted command and whenever all transfer_flag bits are 0.
REQ-025 SHALL, while any flag is set, increment the watchdog counter each cycle; on reaching TIMEOUT_CYC-1 it clears all flags and pulses timeout_evt.
REQ-026 SHALL leave ch_mode unchanged on a watchdog timeout.
REQ-027 SHALL, when a watchdog timeout and an accepted command occur in the same cycle, give the command priority: it is applied and timeout_evt is suppressed.
REQ-028 SHALL size the watchdog counter as $clog2(TIMEOUT_CYC+1) bits, so it never wraps.

Reset
REQ-029 SHALL, with rst_n low at a clk edge, set FSM = IDLE, transfer_flag = 0, ch_mode = 0, cmd_ack = cmd_err = timeout_evt = 0, and watchdog = 0.
REQ-030 SHALL discard a packet that is in progress when reset is asserted; the first packet after reset is decoded normally.

Structure
REQ-031 SHALL place the opcode defaults, the 8'hFF broadcast index and the FSM state encodings in shared package udp_cmd_pkg.
REQ-032 SHALL implement the watchdog as sub-module udp_cmd_wdog with ports clk, rst_n, kick, active, expire and parameter TIMEOUT_CYC.

Verification
REQ-033 SHALL cover legacy start: byte_num = 1, data 32'h31xxxxxx -> transfer_flag = 4'b1111 and one cmd_ack pulse, 2 cycles after pkt_done.
REQ-034 SHALL cover extended start: data 32'h31020000 with byte_num = 4, then 32'h4DFF0300 -> transfer_flag = 4'b0100 and ch_mode = 8'hFF.
REQ-035 SHALL cover rejection: data 32'h31050000 (channel 5 with CH_NUM = 4) and byte_num = 2 packets -> a cmd_err pulse each, outputs unchanged.
REQ-036 SHALL cover the watchdog with TIMEOUT_CYC = 100: a start, then no traffic -> flags clear and timeout_evt pulses at cycle 100; an OP_KEEP sent every 50 cycles -> no timeout.
REQ-037 SHALL cover the edge cases: udp_rec_en with pkt_done in the same cycle -> decoded; a 3-word packet -> only word 0 is used; rst_n low mid-packet -> all outputs 0 and the packet is dropped.
